imem_loader: RTL

- Writer side of the processor's 128-entry instruction memory.
- Accepts a byte stream (e.g. from a UART receiver) and assembles little-endian 32-bit instruction words.
- Issues one write per word into a writable instruction RAM.
- Holds the processor core in reset until the programmed word count has been stored.
- Sits between the serial input path and the instruction RAM's write port; the fetch stage remains the reader.

---
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream, RAM-write and status signals of the instruction memory loader.
// master = stream source / system side, slave = imem_loader.
interface imem_loader_if #(
    parameter int N  = 32,
    parameter int AW = 7
);
    logic          start;
    logic [7:0]    word_count;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_data;
    logic          busy;
    logic          done;
    logic          cpu_reset;
    logic          chk_err;

    modport master (
        output start, word_count, byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data, busy, done, cpu_reset, chk_err
    );

    modport slave (
        input  start, word_count, byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data, busy, done, cpu_reset, chk_err
    );
endinterface

// File: rtl/imem_loader.sv
// Assembles little-endian words from a byte stream, writes them into the instruction RAM and
// holds the core in reset until loading ends. Optional trailing checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int N     = 32,
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input logic          clk,
    input logic          reset,
    imem_loader_if.slave bus
);
    localparam int NB  = N / 8;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2, CHECK = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;
`endif

    function automatic logic [AW:0] sat_count(input logic [7:0] wc);
        logic [AW:0] r;
        if ({24'd0, wc} > 32'(DEPTH)) begin
            r = DEPTH_C;
        end else begin
            r = (AW+1)'(wc);
        end
        return r;
    endfunction

`ifdef IMEM_LOADER_CHECKSUM_EN
    function automatic logic [7:0] csum_add(input logic [7:0] s, input logic [7:0] b);
        return s + b;
    endfunction
`endif

    state_t         state_q, state_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [AW:0]    word_cnt_q, word_cnt_d;
    logic [AW:0]    count_q, count_d;
    logic [N-9:0]   asm_q, asm_d;
    logic           wr_en_q, wr_en_d;
    logic [AW-1:0]  wr_addr_q, wr_addr_d;
    logic [N-1:0]   wr_data_q, wr_data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           byte_ready_q, byte_ready_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]     sum_q, sum_d;
    logic           chk_err_q, chk_err_d;
`endif

    logic           accept_s;
    logic           last_byte_s;
    logic [N-1:0]   word_s;
    logic [AW:0]    word_cnt_inc_s;
    logic [AW:0]    start_cnt_s;

    // Next-state and next-output computation for the load sequencer.
    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        word_cnt_d     = word_cnt_q;
        count_d        = count_q;
        asm_d          = asm_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        busy_d         = busy_q;
        done_d         = done_q;
        byte_ready_d   = byte_ready_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d          = sum_q;
        chk_err_d      = chk_err_q;
`endif
        accept_s       = bus.byte_valid && byte_ready_q;
        last_byte_s    = (byte_cnt_q == BCW'(NB - 1));
        word_s         = {bus.byte_in, asm_q};
        word_cnt_inc_s = word_cnt_q + (AW+1)'(1);
        start_cnt_s    = sat_count(bus.word_count);

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    count_d    = start_cnt_s;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
                    chk_err_d  = 1'b0;
`endif
                    if (start_cnt_s == '0) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        busy_d       = 1'b0;
                        byte_ready_d = 1'b0;
                    end else begin
                        state_d      = LOAD;
                        done_d       = 1'b0;
                        busy_d       = 1'b1;
                        byte_ready_d = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            LOAD: begin
                if (accept_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d = csum_add(sum_q, bus.byte_in);
`endif
                    if (last_byte_s) begin
                        byte_cnt_d = '0;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_cnt_q[AW-1:0];
                        wr_data_d  = word_s;
                        word_cnt_d = word_cnt_inc_s;
                        // byte_ready drops together with the final write strobe
                        if (word_cnt_inc_s == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d      = CHECK;
`else
                            state_d      = DONE;
                            done_d       = 1'b1;
                            busy_d       = 1'b0;
                            byte_ready_d = 1'b0;
`endif
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                        for (int k = 0; k < NB - 1; k++) begin
                            if (BCW'(k) == byte_cnt_q) begin
                                asm_d[8*k +: 8] = bus.byte_in;
                            end else begin
                                asm_d[8*k +: 8] = asm_q[8*k +: 8];
                            end
                        end
                    end
                end else begin
                    state_d = LOAD;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept_s) begin
                    chk_err_d    = (csum_add(sum_q, bus.byte_in) != 8'd0);
                    state_d      = DONE;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    byte_ready_d = 1'b0;
                end else begin
                    state_d = CHECK;
                end
            end
`endif
            default: begin
                state_d      = IDLE;
                done_d       = 1'b0;
                busy_d       = 1'b0;
                byte_ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            count_q      <= '0;
            asm_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            byte_ready_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= 8'd0;
            chk_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            count_q      <= count_d;
            asm_q        <= asm_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            byte_ready_q <= byte_ready_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
            chk_err_q    <= chk_err_d;
`endif
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cpu_reset  = ~done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.chk_err    = chk_err_q;
`else
    assign bus.chk_err    = 1'b0;
`endif
endmodule
